// File: rtl/cfg_bus_master.sv
// Configuration-bus initiator: turns one local read/write request into a full
// 4-phase cs/ack handshake and reports read data or a per-phase timeout.
module cfg_bus_master #(
  parameter logic [15:0] TIMEOUT = 16'd1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_timeout,
  output logic [15:0] timeout_cnt,
  output logic        cfg_cs_n,
  input  logic        cfg_ack_n,
  output logic        cfg_rw,
  output logic [31:0] cfg_addr,
  output logic [31:0] cfg_wdata,
  input  logic [31:0] cfg_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, REL, RESP} state_t;

  state_t      state, nxt;
  logic        ack_meta, ack_s;
  logic [15:0] cnt;
  logic        tflag;
  logic        accept, ack_done, ack_to, rel_to, bad_state;
  logic        cnt_last;

  assign cnt_last     = (cnt == TIMEOUT - 16'd1);
  assign resp_valid   = (state == RESP);
  assign resp_timeout = (state == RESP) && tflag;

  // ack is asynchronous to clk; only the synchronized copy steers the FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_meta <= 1'b1;
      ack_s    <= 1'b1;
    end else begin
      ack_meta <= cfg_ack_n;
      ack_s    <= ack_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt       = state;
    accept    = 1'b0;
    ack_done  = 1'b0;
    ack_to    = 1'b0;
    rel_to    = 1'b0;
    bad_state = 1'b0;
    case (state)
      IDLE: if (req_valid && req_ready) begin
        accept = 1'b1;
        nxt    = REQ;
      end
      REQ: begin
        if (!ack_s) begin
          ack_done = 1'b1;
          nxt      = REL;
        end else if (cnt_last) begin
          ack_to = 1'b1;
          nxt    = REL;
        end
      end
      REL: begin
        if (ack_s) nxt = RESP;
        else if (cnt_last) begin
          rel_to = 1'b1;
          nxt    = RESP;
        end
      end
      RESP: nxt = IDLE;
      default: begin
        bad_state = 1'b1;
        nxt       = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_cs_n    <= 1'b1;
      cfg_rw      <= 1'b0;
      cfg_addr    <= '0;
      cfg_wdata   <= '0;
      req_ready   <= 1'b0;
      resp_rdata  <= '0;
      timeout_cnt <= '0;
      cnt         <= '0;
      tflag       <= 1'b0;
    end else begin
      // ready next cycle only if back in IDLE and ack_s will read released
      req_ready <= (nxt == IDLE) && ack_meta;

      if (accept) begin
        cfg_rw    <= req_rw;
        cfg_addr  <= req_addr;
        cfg_wdata <= req_wdata;
        cfg_cs_n  <= 1'b0;
        tflag     <= 1'b0;
      end
      if (ack_done || ack_to || bad_state) cfg_cs_n <= 1'b1;

      if (ack_done)        resp_rdata <= cfg_rw ? cfg_rdata : 32'h0;
      if (ack_to || rel_to) begin
        resp_rdata <= '0;
        tflag      <= 1'b1;
      end

      if (accept || ack_done || ack_to)       cnt <= '0;
      else if (state == REQ || state == REL)  cnt <= cnt + 16'd1;

      if (state == RESP && tflag && timeout_cnt != 16'hFFFF)
        timeout_cnt <= timeout_cnt + 16'd1;
    end
  end

endmodule
